// File: rtl/pwm_deadtime_gen_if.sv
// Control and status bundle between the PWM core and the dead-time generator.
interface pwm_deadtime_gen_if #(
    parameter int DT_W = 8
);
    logic            en;
    logic            pwm_in;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            cfg_load;
    logic            fault;
    logic            fault_clr;
    logic            out_hi;
    logic            out_lo;
    logic            dt_busy;
    logic            fault_act;

    modport master (
        output en, pwm_in, dt_rise, dt_fall, cfg_load, fault, fault_clr,
        input  out_hi, out_lo, dt_busy, fault_act
    );

    modport slave (
        input  en, pwm_in, dt_rise, dt_fall, cfg_load, fault, fault_clr,
        output out_hi, out_lo, dt_busy, fault_act
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with per-edge dead time, short-pulse absorption and fault kill.
// Optional macro DT_FAULT_LATCH_EN: latched fault (cleared by fault_clr); default is level-following fault.
module pwm_deadtime_gen #(
    parameter int DT_W        = 8,
    parameter int DT_RISE_RST = 4,
    parameter int DT_FALL_RST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_deadtime_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_HI_ON = 2'd2,
        ST_LO_ON = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_dir;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] r_dt_rise_q;
    logic [DT_W-1:0] r_dt_fall_q;
    logic            r_out_hi;
    logic            r_out_lo;
    logic            r_dt_busy;
    logic            r_fault_act;

    state_t          w_state_nx;
    state_t          w_tgt_on;
    logic            w_dir_nx;
    logic [DT_W-1:0] w_cnt_nx;
    logic [DT_W-1:0] w_tgt_dt;
    logic            w_fault_act_nx;
    logic            w_kill;
    logic            w_reload;

    function automatic logic [DT_W-1:0] dt_sel(input logic dir,
                                               input logic [DT_W-1:0] rise,
                                               input logic [DT_W-1:0] fall);
        return dir ? rise : fall;
    endfunction

`ifdef DT_FAULT_LATCH_EN
    // A fault in the same cycle as fault_clr keeps the kill asserted.
    assign w_fault_act_nx = bus.fault | (r_fault_act & ~bus.fault_clr);
`else
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = bus.fault_clr;
    assign w_fault_act_nx     = bus.fault;
`endif

    assign w_kill   = w_fault_act_nx;
    assign w_tgt_dt = dt_sel(bus.pwm_in, r_dt_rise_q, r_dt_fall_q);
    assign w_tgt_on = bus.pwm_in ? ST_HI_ON : ST_LO_ON;

    // Any new target (start-up, PWM edge, or pulse reversal mid-dead-time) reloads the counter.
    always_comb begin
        w_reload = 1'b0;
        case (r_state)
            ST_OFF:   w_reload = 1'b1;
            ST_DEAD:  w_reload = (bus.pwm_in != r_dir);
            ST_HI_ON: w_reload = ~bus.pwm_in;
            ST_LO_ON: w_reload = bus.pwm_in;
            default:  w_reload = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_cnt_nx   = r_cnt;
        if (w_kill || !bus.en) begin
            w_state_nx = ST_OFF;
        end else if (w_reload) begin
            w_dir_nx   = bus.pwm_in;
            w_cnt_nx   = w_tgt_dt;
            // A zero dead time swaps ON states directly on this edge.
            w_state_nx = (w_tgt_dt == '0) ? w_tgt_on : ST_DEAD;
        end else if (r_state == ST_DEAD) begin
            if (r_cnt <= DT_W'(1)) begin
                w_state_nx = r_dir ? ST_HI_ON : ST_LO_ON;
                w_cnt_nx   = '0;
            end else begin
                w_cnt_nx   = r_cnt - DT_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_dir       <= 1'b0;
            r_cnt       <= '0;
            r_dt_rise_q <= DT_W'(DT_RISE_RST);
            r_dt_fall_q <= DT_W'(DT_FALL_RST);
            r_out_hi    <= 1'b0;
            r_out_lo    <= 1'b0;
            r_dt_busy   <= 1'b0;
            r_fault_act <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_dir       <= w_dir_nx;
            r_cnt       <= w_cnt_nx;
            r_out_hi    <= (w_state_nx == ST_HI_ON);
            r_out_lo    <= (w_state_nx == ST_LO_ON);
            r_dt_busy   <= (w_state_nx == ST_DEAD);
            r_fault_act <= w_fault_act_nx;
            if (bus.cfg_load) begin
                r_dt_rise_q <= bus.dt_rise;
                r_dt_fall_q <= bus.dt_fall;
            end
        end
    end

    assign bus.out_hi    = r_out_hi;
    assign bus.out_lo    = r_out_lo;
    assign bus.dt_busy   = r_dt_busy;
    assign bus.fault_act = r_fault_act;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen; observed word is {out_hi, out_lo, dt_busy, fault_act}.
module tb_pwm_deadtime_gen;
    localparam logic [3:0] OFF  = 4'b0000;
    localparam logic [3:0] DEAD = 4'b0010;
    localparam logic [3:0] HI   = 4'b1000;
    localparam logic [3:0] LO   = 4'b0100;
    localparam logic [3:0] KILL = 4'b0001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pwm_deadtime_gen_if #(.DT_W(8)) bus ();

    pwm_deadtime_gen #(
        .DT_W(8),
        .DT_RISE_RST(4),
        .DT_FALL_RST(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] obs();
        return {4'b0, bus.out_hi, bus.out_lo, bus.dt_busy, bus.fault_act};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_for(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            step(1);
            check(tag, obs(), {4'b0, exp});
        end
    endtask

    task automatic load_dt(input logic [7:0] rise, input logic [7:0] fall);
        bus.dt_rise  = rise;
        bus.dt_fall  = fall;
        bus.cfg_load = 1'b1;
        step(1);
        bus.cfg_load = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) check("no_overlap", {7'b0, bus.out_hi & bus.out_lo}, 8'd0);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.pwm_in    = 1'b0;
        bus.dt_rise   = 8'd4;
        bus.dt_fall   = 8'd4;
        bus.cfg_load  = 1'b0;
        bus.fault     = 1'b0;
        bus.fault_clr = 1'b0;

        step(3);
        check("reset_outputs", obs(), {4'b0, OFF});
        rst_n = 1'b1;

        // Start-up: full 4-cycle dead time before out_lo.
        bus.en = 1'b1;
        expect_for("startup_dead", 4, DEAD);
        expect_for("startup_lo", 1, LO);

        // Rising edge with dt_rise=3.
        load_dt(8'd3, 8'd4);
        check("lo_hold", obs(), {4'b0, LO});
        bus.pwm_in = 1'b1;
        expect_for("rise_dead3", 3, DEAD);
        expect_for("rise_hi", 2, HI);

        // Falling edge with dt_fall=4.
        bus.pwm_in = 1'b0;
        expect_for("fall_dead4", 4, DEAD);
        expect_for("fall_lo", 1, LO);

        // 2-cycle pulse shorter than dt_rise=5 is swallowed.
        load_dt(8'd5, 8'd4);
        bus.pwm_in = 1'b1;
        expect_for("short_dead", 2, DEAD);
        bus.pwm_in = 1'b0;
        expect_for("short_reload", 4, DEAD);
        expect_for("short_lo", 1, LO);

        // Zero dead time: direct swap on the sampling edge.
        load_dt(8'd0, 8'd0);
        bus.pwm_in = 1'b1;
        expect_for("zero_hi", 1, HI);
        bus.pwm_in = 1'b0;
        expect_for("zero_lo", 1, LO);
        bus.pwm_in = 1'b1;
        expect_for("zero_hi2", 1, HI);

        // cfg_load mid-dead-time does not disturb the running count.
        load_dt(8'd3, 8'd2);
        bus.pwm_in = 1'b0;
        expect_for("cfg_fall_dead", 2, DEAD);
        expect_for("cfg_fall_lo", 1, LO);
        bus.pwm_in = 1'b1;
        expect_for("cfg_rise_dead", 1, DEAD);
        bus.dt_rise  = 8'd7;
        bus.cfg_load = 1'b1;
        expect_for("cfg_rise_dead", 1, DEAD);
        bus.cfg_load = 1'b0;
        expect_for("cfg_rise_dead", 1, DEAD);
        expect_for("cfg_old_dt_hi", 1, HI);
        bus.pwm_in = 1'b0;
        expect_for("cfg_fall2_dead", 2, DEAD);
        expect_for("cfg_fall2_lo", 1, LO);
        bus.pwm_in = 1'b1;
        expect_for("cfg_new_dt_dead", 7, DEAD);
        expect_for("cfg_new_dt_hi", 1, HI);

        // Fault in the middle of a dead time.
        bus.pwm_in = 1'b0;
        expect_for("flt_pre_dead", 1, DEAD);
        bus.fault = 1'b1;
        expect_for("flt_kill", 1, KILL);
        bus.fault = 1'b0;
`ifdef DT_FAULT_LATCH_EN
        expect_for("flt_latched", 2, KILL);
        bus.fault     = 1'b1;
        bus.fault_clr = 1'b1;
        expect_for("flt_wins_clr", 1, KILL);
        bus.fault     = 1'b0;
        expect_for("flt_clr_dead", 1, DEAD);
        bus.fault_clr = 1'b0;
        expect_for("flt_clr_dead", 1, DEAD);
`else
        expect_for("flt_release_dead", 2, DEAD);
`endif
        expect_for("flt_restart_lo", 1, LO);

        // en=0 forces OFF from an ON state.
        bus.en = 1'b0;
        expect_for("en_off", 2, OFF);

        // Kill beats a dead-time expiry in the same cycle.
        bus.en = 1'b1;
        expect_for("prio_dead", 2, DEAD);
        bus.fault = 1'b1;
        expect_for("prio_kill", 1, KILL);
        bus.fault = 1'b0;
`ifdef DT_FAULT_LATCH_EN
        bus.fault_clr = 1'b1;
        expect_for("prio_restart", 1, DEAD);
        bus.fault_clr = 1'b0;
        expect_for("prio_restart", 1, DEAD);
`else
        expect_for("prio_restart", 2, DEAD);
`endif
        expect_for("prio_lo", 1, LO);

        step(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
